// File: rtl/mem_arbiter_if.sv
// CPU fetch/data ports and unified memory bus of mem_arbiter, bundled as one interface.
// master is the arbiter's view; slave is the view of the CPU and memory around it.
interface mem_arbiter_if;
    logic        inst_ren;
    logic [31:0] inst_addr;
    logic [31:0] inst_data;
    logic        inst_ready;

    logic        data_ren;
    logic        data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_ready;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    logic        cpu_stall;
    logic        bus_err;

    modport master (
        input  inst_ren, inst_addr, data_ren, data_wen, data_addr, data_wdata,
               bus_rdata, bus_ack,
        output inst_data, inst_ready, data_rdata, data_ready,
               bus_req, bus_we, bus_addr, bus_wdata, cpu_stall, bus_err
    );

    modport slave (
        output inst_ren, inst_addr, data_ren, data_wen, data_addr, data_wdata,
               bus_rdata, bus_ack,
        input  inst_data, inst_ready, data_rdata, data_ready,
               bus_req, bus_we, bus_addr, bus_wdata, cpu_stall, bus_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the CPU fetch and load/store ports onto one ack-handshaked memory bus with a
// timeout guard. Define MEM_ARB_RR_EN for round-robin priority (default: data over fetch).
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          cpu_rst,
    input  logic          cpu_en,
    mem_arbiter_if.master mem
);

    typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

    localparam logic [15:0] CntLast = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] inst_data_q, inst_data_d;
    logic        inst_ready_q, inst_ready_d;
    logic [31:0] data_rdata_q, data_rdata_d;
    logic        data_ready_q, data_ready_d;
    logic        bus_err_q, bus_err_d;

    logic        inst_pend;
    logic        data_pend;
    logic        grant_data;
    logic        timeout;

    // A port whose ready pulse is high this cycle is masked so its stale request is not re-granted.
    assign inst_pend = mem.inst_ren & ~inst_ready_q;
    assign data_pend = (mem.data_ren | mem.data_wen) & ~data_ready_q;
    assign timeout   = ~mem.bus_ack & (cnt_q == CntLast);

`ifdef MEM_ARB_RR_EN
    logic last_data_q, last_data_d;

    assign grant_data = data_pend & (~inst_pend | ~last_data_q);
`else
    assign grant_data = data_pend;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        inst_data_d  = inst_data_q;
        inst_ready_d = 1'b0;
        data_rdata_d = data_rdata_q;
        data_ready_d = 1'b0;
        bus_err_d    = bus_err_q;
`ifdef MEM_ARB_RR_EN
        last_data_d  = last_data_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (cpu_en && (inst_pend || data_pend)) begin
                    cnt_d     = 16'd0;
                    bus_req_d = 1'b1;
`ifdef MEM_ARB_RR_EN
                    last_data_d = grant_data;
`endif
                    if (grant_data) begin
                        state_d     = StBusyD;
                        bus_addr_d  = mem.data_addr;
                        bus_we_d    = mem.data_wen;
                        bus_wdata_d = mem.data_wdata;
                    end else begin
                        state_d     = StBusyI;
                        bus_addr_d  = mem.inst_addr;
                        bus_we_d    = 1'b0;
                        bus_wdata_d = 32'd0;
                    end
                end
            end

            StBusyI, StBusyD: begin
                if (mem.bus_ack || timeout) begin
                    state_d   = StIdle;
                    bus_req_d = 1'b0;
                    bus_we_d  = 1'b0;
                    if (!mem.bus_ack) begin
                        bus_err_d = 1'b1;
                    end
                    if (state_q == StBusyI) begin
                        inst_ready_d = 1'b1;
                        inst_data_d  = mem.bus_ack ? mem.bus_rdata : 32'd0;
                    end else begin
                        data_ready_d = 1'b1;
                        // A completed store leaves the load result untouched.
                        if (!mem.bus_ack) begin
                            data_rdata_d = 32'd0;
                        end else if (!bus_we_q) begin
                            data_rdata_d = mem.bus_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            default: begin
                state_d   = StIdle;
                bus_req_d = 1'b0;
                bus_we_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (cpu_rst) begin
            state_q      <= StIdle;
            cnt_q        <= 16'd0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= 32'd0;
            bus_wdata_q  <= 32'd0;
            inst_data_q  <= 32'd0;
            inst_ready_q <= 1'b0;
            data_rdata_q <= 32'd0;
            data_ready_q <= 1'b0;
            bus_err_q    <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_data_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            inst_data_q  <= inst_data_d;
            inst_ready_q <= inst_ready_d;
            data_rdata_q <= data_rdata_d;
            data_ready_q <= data_ready_d;
            bus_err_q    <= bus_err_d;
`ifdef MEM_ARB_RR_EN
            last_data_q  <= last_data_d;
`endif
        end
    end

    assign mem.bus_req    = bus_req_q;
    assign mem.bus_we     = bus_we_q;
    assign mem.bus_addr   = bus_addr_q;
    assign mem.bus_wdata  = bus_wdata_q;
    assign mem.inst_data  = inst_data_q;
    assign mem.inst_ready = inst_ready_q;
    assign mem.data_rdata = data_rdata_q;
    assign mem.data_ready = data_ready_q;
    assign mem.bus_err    = bus_err_q;
    assign mem.cpu_stall  = inst_pend | data_pend;

    bus_req_tracks_state: assert property (@(posedge clk) disable iff (cpu_rst)
        bus_req_q == (state_q != StIdle));

    single_ready: assert property (@(posedge clk) disable iff (cpu_rst)
        !(inst_ready_q && data_ready_q));

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, contention/reset sequences and a
// randomized run checked against a transaction-level reference model and a memory model.
module tb_mem_arbiter;

    localparam int unsigned TO = 4;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk     = 1'b0;
    logic cpu_rst = 1'b1;
    logic cpu_en  = 1'b1;

    mem_arbiter_if bus_if ();

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk     (clk),
        .cpu_rst (cpu_rst),
        .cpu_en  (cpu_en),
        .mem     (bus_if)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- memory model / responder ----------------
    logic [31:0] mem_model [logic [31:0]];
    int resp_waits = 0;
    bit resp_rand  = 1'b0;
    bit force_ack  = 1'b0;
    bit resp_busy  = 1'b0;
    int resp_cnt   = 0;
    int resp_w     = 0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a ^ 32'hA5A5_5A5A;
    endfunction

    always @(posedge clk) begin
        #2;
        if (bus_if.bus_req) begin
            if (!resp_busy) begin
                resp_busy = 1'b1;
                resp_cnt  = 0;
                resp_w    = resp_rand ? int'($urandom_range(0, 5)) : resp_waits;
            end else begin
                resp_cnt++;
            end
            if (resp_cnt == resp_w) begin
                bus_if.bus_ack   = 1'b1;
                bus_if.bus_rdata = mem_rd(bus_if.bus_addr);
                if (bus_if.bus_we) mem_model[bus_if.bus_addr] = bus_if.bus_wdata;
            end else begin
                bus_if.bus_ack   = 1'b0;
                bus_if.bus_rdata = $urandom;
            end
        end else begin
            resp_busy        = 1'b0;
            bus_if.bus_ack   = force_ack;
            bus_if.bus_rdata = $urandom;
        end
    end

    // ---------------- reference model (checked every cycle) ----------------
    int          owner = 0;  // 0 none, 1 fetch, 2 data
    int          elapsed = 0;
    bit          m_we = 0, last_data = 0, grant_now = 0, pick_data = 0;
    bit          exp_ir = 0, exp_dr = 0, exp_err = 0;
    logic [31:0] exp_id = 0, exp_dd = 0, exp_addr = 0, exp_wdata = 0;
    bit          prev_rst = 1, prev_en = 0, prev_ip = 0, prev_dp = 0, prev_ack = 0, prev_dwen = 0;
    logic [31:0] prev_brdata = 0, prev_iaddr = 0, prev_daddr = 0, prev_dwdata = 0;

    always @(negedge clk) begin
        grant_now = 1'b0;
        exp_ir    = 1'b0;
        exp_dr    = 1'b0;
        if (prev_rst) begin
            owner = 0; elapsed = 0; exp_id = 0; exp_dd = 0; exp_err = 0; last_data = 0;
        end else if (owner != 0) begin
            if (prev_ack || elapsed == int'(TO) - 1) begin
                if (!prev_ack) exp_err = 1'b1;
                if (owner == 1) begin
                    exp_ir = 1'b1;
                    exp_id = prev_ack ? prev_brdata : 32'd0;
                end else begin
                    exp_dr = 1'b1;
                    if (!prev_ack) exp_dd = 32'd0;
                    else if (!m_we) exp_dd = prev_brdata;
                end
                owner = 0;
            end else begin
                elapsed++;
            end
        end else if (prev_en && (prev_ip || prev_dp)) begin
            pick_data = prev_dp && (!prev_ip || !RR || !last_data);
            last_data = pick_data;
            owner     = pick_data ? 2 : 1;
            elapsed   = 0;
            grant_now = 1'b1;
            m_we      = pick_data && prev_dwen;
            exp_addr  = pick_data ? prev_daddr : prev_iaddr;
            exp_wdata = pick_data ? prev_dwdata : 32'd0;
        end

        check("m_bus_req", 32'(bus_if.bus_req), 32'(owner != 0));
        check("m_inst_ready", 32'(bus_if.inst_ready), 32'(exp_ir));
        check("m_data_ready", 32'(bus_if.data_ready), 32'(exp_dr));
        check("m_inst_data", bus_if.inst_data, exp_id);
        check("m_data_rdata", bus_if.data_rdata, exp_dd);
        check("m_bus_err", 32'(bus_if.bus_err), 32'(exp_err));
        check("m_cpu_stall", 32'(bus_if.cpu_stall),
              32'((bus_if.inst_ren && !exp_ir) ||
                  ((bus_if.data_ren || bus_if.data_wen) && !exp_dr)));
        if (owner != 0) check("m_bus_we", 32'(bus_if.bus_we), 32'(m_we));
        if (grant_now) begin
            check("m_bus_addr", bus_if.bus_addr, exp_addr);
            check("m_bus_wdata", bus_if.bus_wdata, exp_wdata);
        end

        prev_rst    = cpu_rst;
        prev_en     = cpu_en;
        prev_ip     = bus_if.inst_ren && !exp_ir;
        prev_dp     = (bus_if.data_ren || bus_if.data_wen) && !exp_dr;
        prev_dwen   = bus_if.data_wen;
        prev_ack    = bus_if.bus_ack;
        prev_brdata = bus_if.bus_rdata;
        prev_iaddr  = bus_if.inst_addr;
        prev_daddr  = bus_if.data_addr;
        prev_dwdata = bus_if.data_wdata;
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        bit          is_data;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        int          exp_cycle;
        logic [31:0] exp_data;
        bit          exp_err;
    } vec_t;

    task automatic drop_all();
        bus_if.inst_ren = 1'b0;
        bus_if.data_ren = 1'b0;
        bus_if.data_wen = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int   c = 0, nreq = 0, nwe = 0;
        bit   done = 1'b0;
        logic rdy;
        resp_waits = v.waits;
        if (v.is_data) begin
            bus_if.data_ren   = !v.we;
            bus_if.data_wen   = v.we;
            bus_if.data_addr  = v.addr;
            bus_if.data_wdata = v.wdata;
        end else begin
            bus_if.inst_ren  = 1'b1;
            bus_if.inst_addr = v.addr;
        end
        @(negedge clk);
        check("v_stall_c0", 32'(bus_if.cpu_stall), 32'd1);
        while (!done && c < 20) begin
            tick();
            c++;
            rdy = v.is_data ? bus_if.data_ready : bus_if.inst_ready;
            if (rdy) begin
                done = 1'b1;
                drop_all();
            end
            @(negedge clk);
            if (!done) begin
                check("v_stall_wait", 32'(bus_if.cpu_stall), 32'd1);
                if (bus_if.bus_req) begin
                    nreq++;
                    if (bus_if.bus_we) nwe++;
                    if (nreq == 1) check("v_bus_addr", bus_if.bus_addr, v.addr);
                end
            end
        end
        check("v_latency", 32'(c), 32'(v.exp_cycle));
        check("v_data", v.is_data ? bus_if.data_rdata : bus_if.inst_data, v.exp_data);
        check("v_err", 32'(bus_if.bus_err), 32'(v.exp_err));
        check("v_stall_done", 32'(bus_if.cpu_stall), 32'd0);
        check("v_req_cycles", 32'(nreq), 32'(v.exp_cycle - 1));
        check("v_we_cycles", 32'(nwe), v.we ? 32'(v.exp_cycle - 1) : 32'd0);
        tick();
    endtask

    vec_t vecs[8];
    int   winner;
    int   exp_order[3];
    bit   i_act, d_act, got;

    initial begin
        bus_if.inst_ren = 0; bus_if.inst_addr = 0; bus_if.data_ren = 0; bus_if.data_wen = 0;
        bus_if.data_addr = 0; bus_if.data_wdata = 0; bus_if.bus_ack = 0; bus_if.bus_rdata = 0;

        mem_model[32'h40]  = 32'h8C01_0004;
        mem_model[32'h44]  = 32'h2402_0007;
        mem_model[32'h200] = 32'h1234_5678;
        //            data we addr        wdata         waits cyc data           err
        vecs[0] = '{1'b0, 1'b0, 32'h40,  32'h0,         0, 2, 32'h8C01_0004, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 3, 5, 32'h0,         1'b0};
        vecs[2] = '{1'b1, 1'b0, 32'h100, 32'h0,         1, 3, 32'hDEAD_BEEF, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 32'h44,  32'h0,         2, 4, 32'h2402_0007, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 32'h200, 32'h0,         3, 5, 32'h1234_5678, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 32'h80,  32'h0,         7, 5, 32'h0,         1'b1};
        vecs[6] = '{1'b1, 1'b1, 32'h104, 32'hCAFE_F00D, 4, 5, 32'h0,         1'b1};
        vecs[7] = '{1'b1, 1'b0, 32'h100, 32'h0,         0, 2, 32'hDEAD_BEEF, 1'b1};

        @(negedge clk);
        check("rst_bus_req", 32'(bus_if.bus_req), 32'd0);
        check("rst_bus_we", 32'(bus_if.bus_we), 32'd0);
        check("rst_bus_addr", bus_if.bus_addr, 32'd0);
        check("rst_bus_wdata", bus_if.bus_wdata, 32'd0);
        check("rst_readies", 32'({bus_if.inst_ready, bus_if.data_ready}), 32'd0);
        check("rst_bus_err", 32'(bus_if.bus_err), 32'd0);
        tick();
        cpu_rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Reset clears the sticky error.
        cpu_rst = 1'b1;
        tick();
        cpu_rst = 1'b0;
        @(negedge clk);
        check("rst_clears_err", 32'(bus_if.bus_err), 32'd0);

        // Reset in the middle of a load, then a late ack.
        tick();
        resp_waits = 9;
        bus_if.data_ren  = 1'b1;
        bus_if.data_addr = 32'h600;
        tick();
        @(negedge clk);
        check("mid_busy", 32'(bus_if.bus_req), 32'd1);
        tick();
        cpu_rst = 1'b1;
        tick();
        cpu_rst   = 1'b0;
        force_ack = 1'b1;
        drop_all();
        @(negedge clk);
        check("mid_req_drop", 32'(bus_if.bus_req), 32'd0);
        check("mid_no_ready", 32'(bus_if.data_ready), 32'd0);
        check("mid_addr_zero", bus_if.bus_addr, 32'd0);
        tick();
        force_ack = 1'b0;
        @(negedge clk);
        check("late_ack_ready", 32'(bus_if.data_ready), 32'd0);
        check("late_ack_req", 32'(bus_if.bus_req), 32'd0);

        // Contention rounds, separated by cpu_en so each grant sees both ports pending.
        cpu_rst = 1'b1;
        tick();
        cpu_rst    = 1'b0;
        cpu_en     = 1'b0;
        resp_waits = 0;
        i_act = 0; d_act = 0;
        exp_order[0] = 2;
        exp_order[1] = RR ? 1 : 2;
        exp_order[2] = 2;
        tick();
        for (int r = 0; r < 3; r++) begin
            if (!i_act) begin
                bus_if.inst_ren = 1'b1; bus_if.inst_addr = 32'h400 + 32'(8 * r); i_act = 1;
            end
            if (!d_act) begin
                bus_if.data_ren = 1'b1; bus_if.data_addr = 32'h500 + 32'(8 * r); d_act = 1;
            end
            cpu_en = 1'b1;
            tick();
            cpu_en = 1'b0;
            @(negedge clk);
            winner = !bus_if.bus_req ? 0 :
                     (bus_if.bus_addr == bus_if.data_addr) ? 2 :
                     (bus_if.bus_addr == bus_if.inst_addr) ? 1 : 0;
            check("grant_order", 32'(winner), 32'(exp_order[r]));
            got = 1'b0;
            for (int k = 0; k < 10 && !got; k++) begin
                tick();
                if (bus_if.data_ready) begin bus_if.data_ren = 1'b0; d_act = 0; got = 1; end
                if (bus_if.inst_ready) begin bus_if.inst_ren = 1'b0; i_act = 0; got = 1; end
            end
            check("grant_done", 32'(got), 32'd1);
            tick();
        end
        cpu_en = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            tick();
            if (bus_if.inst_ready) begin got = 1; drop_all(); end
        end
        check("loser_served", 32'(got), 32'd1);
        tick();

        // Randomized traffic against the reference model.
        resp_rand = 1'b1;
        i_act = 0; d_act = 0;
        for (int k = 0; k < 800; k++) begin
            tick();
            cpu_rst = 1'b0;
            if ($urandom_range(0, 199) == 0) begin
                cpu_rst = 1'b1;
                drop_all();
                i_act = 0; d_act = 0;
                continue;
            end
            cpu_en = ($urandom_range(0, 7) != 0);
            if (i_act && bus_if.inst_ready) begin i_act = 0; bus_if.inst_ren = 1'b0; end
            if (d_act && bus_if.data_ready) begin
                d_act = 0; bus_if.data_ren = 1'b0; bus_if.data_wen = 1'b0;
            end
            if (!i_act && $urandom_range(0, 3) == 0) begin
                i_act = 1;
                bus_if.inst_ren  = 1'b1;
                bus_if.inst_addr = 32'($urandom_range(0, 63)) << 2;
            end
            if (!d_act && $urandom_range(0, 3) == 0) begin
                d_act = 1;
                bus_if.data_wen   = $urandom_range(0, 1) == 1;
                bus_if.data_ren   = !bus_if.data_wen;
                bus_if.data_addr  = 32'($urandom_range(0, 63)) << 2;
                bus_if.data_wdata = $urandom;
            end
        end
        cpu_rst = 1'b0;
        drop_all();
        repeat (12) tick();
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
